// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message controller: packs a pre-padded 32-bit word stream into 512-bit blocks,
// sequences one sha256_core per block and returns the digest. Optional SHA_BLKCNT_EN adds blk_count.
module sha256_msg_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_hash_init,
  output logic         core_use_init,
  input  logic [255:0] core_hash_out,
  input  logic         core_ready,
  output logic         digest_valid,
  output logic [255:0] digest,
  input  logic         digest_ack,
  output logic         busy,
`ifdef SHA_BLKCNT_EN
  output logic [15:0]  blk_count,
`endif
  output logic         err
);

  localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE, S_ERR} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           last_blk_q, last_blk_d;
  logic           later_q, later_d;
  logic [255:0]   chain_q, chain_d;
  logic [511:0]   block_q, block_d;
  logic [255:0]   digest_q, digest_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           in_ready_q, in_ready_d;
  logic           start_q, start_d;
  logic           use_init_q, use_init_d;
  logic           dv_q, dv_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
`ifdef SHA_BLKCNT_EN
  logic [15:0]    blkcnt_q, blkcnt_d;
`endif

  logic           accept_c;
  logic           complete_c;
  logic [3:0]     widx_c;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_blk_d = last_blk_q;
    later_d    = later_q;
    chain_d    = chain_q;
    block_d    = block_q;
    digest_d   = digest_q;
    wait_d     = '0;
`ifdef SHA_BLKCNT_EN
    blkcnt_d   = blkcnt_q;
`endif
    accept_c   = in_valid && in_ready_q;
    // the first WAIT cycle still sees the core's stale idle-ready
    complete_c = (state_q == S_WAIT) && (wait_q != '0) && core_ready;
    widx_c     = (state_q == S_IDLE) ? 4'd0 : cnt_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept_c) begin
          if (state_q == S_IDLE) begin
            later_d = 1'b0;
`ifdef SHA_BLKCNT_EN
            blkcnt_d = 16'd0;
`endif
          end
          if (in_last && (widx_c != 4'd15)) begin
            state_d = S_ERR;
          end else begin
            block_d[{~widx_c, 5'h1f} -: 32] = in_data;
            cnt_d = widx_c + 4'd1;
            if (widx_c == 4'd15) begin
              last_blk_d = in_last;
              state_d    = S_START;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (complete_c) begin
          chain_d = core_hash_out;
          later_d = 1'b1;
`ifdef SHA_BLKCNT_EN
          if (blkcnt_q != 16'hFFFF) blkcnt_d = blkcnt_q + 16'd1;
`endif
          if (last_blk_q) begin
            digest_d = core_hash_out;
            state_d  = S_DONE;
          end else begin
            cnt_d   = 4'd0;
            state_d = S_LOAD;
          end
        end else if (wait_q == WCW'(TIMEOUT_CYCLES)) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_DONE: begin
        if (digest_ack) begin
          chain_d = '0;
          state_d = S_IDLE;
`ifdef SHA_BLKCNT_EN
          blkcnt_d = 16'd0;
`endif
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    start_d    = (state_d == S_START);
    dv_d       = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
    err_d      = (state_d == S_ERR);
    use_init_d = use_init_q;
    if (state_d == S_START)     use_init_d = later_d;
    else if (state_d == S_IDLE) use_init_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      last_blk_q <= 1'b0;
      later_q    <= 1'b0;
      chain_q    <= '0;
      block_q    <= '0;
      digest_q   <= '0;
      wait_q     <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      use_init_q <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SHA_BLKCNT_EN
      blkcnt_q   <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_blk_q <= last_blk_d;
      later_q    <= later_d;
      chain_q    <= chain_d;
      block_q    <= block_d;
      digest_q   <= digest_d;
      wait_q     <= wait_d;
      in_ready_q <= in_ready_d;
      start_q    <= start_d;
      use_init_q <= use_init_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef SHA_BLKCNT_EN
      blkcnt_q   <= blkcnt_d;
`endif
    end
  end

  assign in_ready       = in_ready_q;
  assign core_start     = start_q;
  assign core_block     = block_q;
  assign core_hash_init = chain_q;
  assign core_use_init  = use_init_q;
  assign digest_valid   = dv_q;
  assign digest         = digest_q;
  assign busy           = busy_q;
  assign err            = err_q;
`ifdef SHA_BLKCNT_EN
  assign blk_count      = blkcnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Scoreboard bench for sha256_msg_ctrl with a canned-response core stub.
module tb_sha256_msg_ctrl;

  localparam int unsigned TO = 15;

  localparam logic [255:0] D_AAA = 256'h9834876dcfb05cb167a5c24953eba58c4ac89b1adf57f28e89b5b5c7ee9da1ba;
  localparam logic [255:0] H_ABC1 = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] D_ABC = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] AAA_W [16] = '{32'h61616180, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                         32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
  localparam logic [31:0] ABC1_W [16] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [31:0] ABC2_W [16] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                          32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

  logic         clk, rst_n, in_valid, in_ready, in_last;
  logic [31:0]  in_data;
  logic         core_start, core_use_init, core_ready;
  logic [511:0] core_block;
  logic [255:0] core_hash_init, core_hash_out, digest;
  logic         digest_valid, digest_ack, busy, err;
`ifdef SHA_BLKCNT_EN
  logic [15:0]  blk_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [255:0] exp_dig_q [$];
  logic [15:0]  exp_cnt_q [$];
  logic         exp_ui_q  [$];
  logic [255:0] exp_hi_q  [$];

  logic stub_hang = 1'b0;
  int   stub_lat  = 6;

  sha256_msg_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_start(core_start), .core_block(core_block), .core_hash_init(core_hash_init),
    .core_use_init(core_use_init), .core_hash_out(core_hash_out), .core_ready(core_ready),
    .digest_valid(digest_valid), .digest(digest), .digest_ack(digest_ack), .busy(busy),
`ifdef SHA_BLKCNT_EN
    .blk_count(blk_count),
`endif
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic logic [511:0] blk_of(input logic [31:0] w [16]);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = w[k];
    return b;
  endfunction

  // Canned core: only correctly routed block/init/use_init combinations yield the real hashes
  function automatic logic [255:0] core_fn(input logic [511:0] b, input logic [255:0] hi, input logic ui);
    if (!ui && b == blk_of(AAA_W))                   return D_AAA;
    if (!ui && b == blk_of(ABC1_W))                  return H_ABC1;
    if (ui && hi == H_ABC1 && b == blk_of(ABC2_W))   return D_ABC;
    return b[255:0] ^ hi ^ 256'h5a5a;
  endfunction

  // Core stub: ready high when idle, drops from the second WAIT cycle while computing
  initial begin
    logic [511:0] sb;
    logic [255:0] si;
    logic         su;
    core_ready    = 1'b1;
    core_hash_out = '0;
    forever begin
      @(negedge clk);
      if (core_start && rst_n) begin
        sb = core_block;
        si = core_hash_init;
        su = core_use_init;
        @(posedge clk);
        @(posedge clk);
        #1 core_ready = 1'b0;
        repeat (stub_lat) @(posedge clk);
        if (stub_hang) wait (!stub_hang);
        #1;
        core_hash_out = core_fn(sb, si, su);
        core_ready    = 1'b1;
      end
    end
  end

  // Monitor: pops expected start and digest records as the DUT presents them
  initial begin
    logic cs_prev, dv_prev, ui;
    logic [255:0] hi, d;
    logic [15:0] c;
    cs_prev = 1'b0;
    dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        check("start_one_cycle", 256'(cs_prev), 256'(0));
        if (exp_ui_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_core_start: got core_start=1 expected none");
        end else begin
          ui = exp_ui_q.pop_front();
          hi = exp_hi_q.pop_front();
          check("start_use_init", 256'(core_use_init), 256'(ui));
          check("start_hash_init", core_hash_init, hi);
        end
      end
      if (digest_valid && !dv_prev) begin
        if (exp_dig_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_digest: got %h expected none", digest);
        end else begin
          d = exp_dig_q.pop_front();
          c = exp_cnt_q.pop_front();
          check("digest", digest, d);
`ifdef SHA_BLKCNT_EN
          check("blk_count", 256'(blk_count), 256'(c));
`endif
        end
      end
      cs_prev = core_start;
      dv_prev = digest_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the word transferred
  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL handshake_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_block(input logic [31:0] w [16], input logic last);
    for (int k = 0; k < 16; k++) send_word(w[k], (k == 15) ? last : 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_digest();
    int n;
    n = 0;
    while (!digest_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!digest_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL digest_timeout: got digest_valid=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic ack_digest();
    digest_ack = 1'b1;
    @(negedge clk);
    digest_ack = 1'b0;
    check("after_ack_busy", 256'(busy), 256'(0));
    check("after_ack_in_ready", 256'(in_ready), 256'(1));
    check("after_ack_dv", 256'(digest_valid), 256'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 256'(in_ready), 256'(0));
    check({tag, "_core_start"}, 256'(core_start), 256'(0));
    check({tag, "_use_init"}, 256'(core_use_init), 256'(0));
    check({tag, "_dv"}, 256'(digest_valid), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_err"}, 256'(err), 256'(0));
    check({tag, "_block_hi"}, core_block[511:256], 256'(0));
    check({tag, "_block_lo"}, core_block[255:0], 256'(0));
    check({tag, "_hash_init"}, core_hash_init, 256'(0));
    check({tag, "_digest"}, digest, 256'(0));
`ifdef SHA_BLKCNT_EN
    check({tag, "_blk_count"}, 256'(blk_count), 256'(0));
`endif
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int got_n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    digest_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 256'(in_ready), 256'(1));
    check("idle_busy", 256'(busy), 256'(0));

    // single-block "aaa"
    exp_ui_q.push_back(1'b0); exp_hi_q.push_back('0);
    exp_dig_q.push_back(D_AAA); exp_cnt_q.push_back(16'd1);
    send_block(AAA_W, 1'b1);
    check("start_in_ready", 256'(in_ready), 256'(0));
    check("start_busy", 256'(busy), 256'(1));
    wait_digest();
    ack_digest();

    // two-block message with a 5-cycle delayed ack
    exp_ui_q.push_back(1'b0); exp_hi_q.push_back('0);
    exp_ui_q.push_back(1'b1); exp_hi_q.push_back(H_ABC1);
    exp_dig_q.push_back(D_ABC); exp_cnt_q.push_back(16'd2);
    send_block(ABC1_W, 1'b0);
    send_block(ABC2_W, 1'b1);
    wait_digest();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("done_hold_dv", 256'(digest_valid), 256'(1));
      check("done_hold_digest", digest, D_ABC);
      check("done_hold_in_ready", 256'(in_ready), 256'(0));
    end
    ack_digest();

    // reset in the middle of WAIT; the late core response must be ignored
    exp_ui_q.push_back(1'b0); exp_hi_q.push_back('0);
    send_block(AAA_W, 1'b1);
    repeat (3) @(negedge clk);
    check("midwait_busy", 256'(busy), 256'(1));
    pulse_reset();
    check_reset_outputs("midwait_rst");
    repeat (20) @(negedge clk);
    check("post_rst_busy", 256'(busy), 256'(0));
    check("post_rst_dv", 256'(digest_valid), 256'(0));
    check("post_rst_in_ready", 256'(in_ready), 256'(1));

    exp_ui_q.push_back(1'b0); exp_hi_q.push_back('0);
    exp_dig_q.push_back(D_AAA); exp_cnt_q.push_back(16'd1);
    send_block(AAA_W, 1'b1);
    wait_digest();
    ack_digest();

    // in_last on word 7
    for (int k = 0; k < 7; k++) send_word(AAA_W[k], 1'b0);
    send_word(32'hDEADBEEF, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("early_last_err", 256'(err), 256'(1));
    check("early_last_in_ready", 256'(in_ready), 256'(0));
    check("early_last_busy", 256'(busy), 256'(1));
    check("early_last_discard", 256'(core_block[287 -: 32]), 256'(0));
    repeat (10) @(negedge clk);
    check("err_sticky", 256'(err), 256'(1));
    check("err_no_start", 256'(core_start), 256'(0));
    pulse_reset();
    @(negedge clk);
    check("err_cleared", 256'(err), 256'(0));
    check("err_cleared_in_ready", 256'(in_ready), 256'(1));

    // hung core: ERR after exactly TO+1 WAIT cycles
    stub_hang = 1'b1;
    exp_ui_q.push_back(1'b0); exp_hi_q.push_back('0);
    send_block(AAA_W, 1'b1);
    check("timeout_start", 256'(core_start), 256'(1));
    got_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (err && got_n == 0) got_n = n;
    end
    check("timeout_cycles", 256'(got_n), 256'(TO + 2));
    check("timeout_in_ready", 256'(in_ready), 256'(0));
    pulse_reset();
    stub_hang = 1'b0;
    repeat (5) @(negedge clk);
    check("final_busy", 256'(busy), 256'(0));
    check("start_queue_empty", 256'(exp_ui_q.size()), 256'(0));
    check("digest_queue_empty", 256'(exp_dig_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected $finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_msg_ctrl.md
SHA256_MSG_CTRL -- requirements
Module: sha256_msg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum number of WAIT cycles allowed per block before error.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_data input 32, in_last input 1: pre-padded message word stream, big-endian; in_last marks the final word of the message.
REQ-005 SHALL have ports core_start output 1, core_block output 512, core_hash_init output 256, core_use_init output 1, core_hash_out input 256, core_ready input 1: drive one sha256_core.
REQ-006 SHALL have ports digest_valid output 1, digest output 256, digest_ack input 1, busy output 1, err output 1.

Function
REQ-007 SHALL implement states IDLE, LOAD, START, WAIT, DONE, ERR.
REQ-008 in_ready SHALL be 1 only in IDLE and LOAD; a word transfers when in_valid and in_ready are both 1 on an edge.
REQ-009 Word k (0..15) of a block SHALL be written to core_block[511-32k -: 32]; a 4-bit word counter SHALL wrap 15->0.
REQ-010 IDLE: first accepted word SHALL clear the block count and move to LOAD with counter=1.
REQ-011 Accepting word 15 SHALL move to START and latch in_last as last_blk; in_ready SHALL be 0 in the following cycle.
REQ-012 in_last=1 on any word other than word 15 SHALL move to ERR; that word is discarded and core_start is never issued.
REQ-013 START SHALL last exactly one cycle with core_start=1; core_use_init=0 for the first block of a message, 1 for every later block; core_hash_init = chaining register.
REQ-014 WAIT SHALL ignore core_ready in its first cycle and complete on the first later cycle with core_ready=1.
REQ-015 On completion, chaining register SHALL load core_hash_out; if last_blk=0 go to LOAD (counter=0), else go to DONE with digest=core_hash_out.
REQ-016 If WAIT lasts TIMEOUT_CYCLES+1 cycles without completion, SHALL go to ERR.
REQ-017 DONE: digest_valid=1 and digest stable until digest_ack=1; then go to IDLE and clear chaining register; digest_ack outside DONE SHALL be ignored.
REQ-018 ERR: err=1, in_ready=0, core_start=0; SHALL remain until reset.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 core_block and core_hash_init SHALL remain stable from START through end of WAIT.

Reset
REQ-021 rst_n=0 sampled on an edge SHALL, from any state including mid-WAIT, force IDLE with counter, last_blk, chaining register, core_block, digest and block count all 0.
REQ-022 Reset values: in_ready=0 during reset cycle then 1 in IDLE; core_start, core_use_init, digest_valid, busy, err all 0; core_block, core_hash_init, digest all 0.
REQ-023 Core response arriving after a reset SHALL be ignored (controller in IDLE).

Configuration
REQ-024 Macro SHA_BLKCNT_EN defined: SHALL add output blk_count[15:0] = blocks completed in current message, incremented at each WAIT completion, saturating at 16'hFFFF, cleared on entry to IDLE from DONE and on reset.
REQ-025 Macro SHA_BLKCNT_EN undefined: port blk_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-026 "aaa" block (word0=61616180, word15=00000018, in_last on word15) -> one core_start, core_use_init=0, digest=9834876dcfb05cb167a5c24953eba58c4ac89b1adf57f28e89b5b5c7ee9da1ba.
REQ-027 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" padded -> second start with core_use_init=1, core_hash_init=first-block result, digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; blk_count=2 when SHA_BLKCNT_EN.
REQ-028 in_last=1 on word 7 -> err=1 next cycle, in_ready=0, no core_start ever.
REQ-029 Core stub holding core_ready=0, TIMEOUT_CYCLES=15 -> err=1 after exactly 16 WAIT cycles.
REQ-030 rst_n=0 for one cycle mid-WAIT -> IDLE with all outputs at reset values; subsequent "aaa" message yields correct digest.
REQ-031 digest_ack delayed 5 cycles in DONE -> digest_valid=1, digest unchanged, in_ready=0 throughout; IDLE on cycle after ack.
